conv_input_streamer: RTL and testbench
======================================

# conv_input_streamer

Feeds the convolution accelerator's `a` (activation) and `b` (weight) input ports. It reads a stored input feature map and kernel set from two single-port source memories and sends them as two valid/ready streams, in the exact beat order the accelerator consumes them. Zero-padding at feature-map borders is inserted locally, without a memory read. It sits between the testbench/host memories and the accelerator top.

## Interface
- `IO_DATA_WIDTH`, 16: width of activation, weight and stream data
- `FEATURE_MAP_WIDTH`, 1024: input/output map width (x)
- `FEATURE_MAP_HEIGHT`, 1024: input/output map height (y)
- `INPUT_NB_CHANNELS`, 64: input channels
- `OUTPUT_NB_CHANNELS`, 64: output channels
- `KERNEL_SIZE`, 3: kernel side, odd; PAD = (KERNEL_SIZE-1)/2
- `SRC_MEM_HEIGHT`, 1<<20: depth of each source memory; AW = $clog2(SRC_MEM_HEIGHT)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_in` in 1: synchronous, active-high reset
- `start` in 1: begin one full layer stream; sampled only in IDLE
- `running` out 1: high in RUN and DRAIN
- `done` out 1: one-cycle pulse on DRAIN→IDLE
- `act_mem_read_addr` out AW: activation address
- `act_mem_read_en` out 1: activation read strobe
- `act_mem_qout` in IO_DATA_WIDTH: activation data, valid the cycle after read_en
- `wgt_mem_read_addr` out AW: weight address
- `wgt_mem_read_en` out 1: weight read strobe
- `wgt_mem_qout` in IO_DATA_WIDTH: weight data, valid the cycle after read_en
- `a_data` out IO_DATA_WIDTH: activation beat
- `a_valid` out 1: a_data valid
- `a_ready` in 1: consumer accepts a beat
- `b_data` out IO_DATA_WIDTH: weight beat
- `b_valid` out 1: b_data valid
- `b_ready` in 1: consumer accepts b beat

## Operation
- Loop order, outermost first: y, x, oc, ic, ky, kx. Each index tuple produces one `a` beat and one `b` beat. Total beats N = H·W·OC·IC·K·K per channel.
- yi = y+ky-PAD and xi = x+kx-PAD. pad = (yi<0 or yi≥H or xi<0 or xi≥W).
- Activation address = (yi·W + xi)·IC + ic. No read is issued when pad is set; the beat value is 0.
- Weight address = ((oc·IC + ic)·K + ky)·K + kx. Always read.
- Both reads issue in the same cycle, one tuple per cycle maximum. The 1-cycle-late qout is pushed into a per-channel FIFO of depth 2. A registered pad flag is carried alongside to select 0.
- Issue condition: state RUN and, for both channels, occ + inflight − pop_this_cycle < 2. Otherwise read_en stays low and the loop counters hold.
- `a` and `b` drain independently. Stalling one channel eventually blocks issue for both.
- Stream rule: while valid is high and ready is low, data and valid hold stable. A beat transfers on a cycle with valid && ready.
- FSM states and transitions:
  - IDLE → RUN on `start`. Counters clear to 0.
  - RUN → DRAIN in the cycle the last tuple (all indices at max) issues.
  - DRAIN → IDLE when both FIFOs are empty and nothing is in flight. `done`=1 in that cycle's successor.
- `start` is ignored in RUN and DRAIN.
- Index arithmetic is done in signed widths of $clog2(dim)+2 to avoid wrap on negative yi/xi. Addresses are truncated to AW.

## Timing
- Reset values: running=0, done=0, a_valid=0, b_valid=0, a_data=0, b_data=0, both read_en=0, both read_addr=0. FSM goes to IDLE, FIFOs empty, counters 0.
- Reset asserted mid-operation: all of the above apply in the cycle after the sampling edge. In-flight memory data is discarded.
- Start latency: `start` sampled at edge 0, state RUN in cycle 1, first reads in cycle 1, qout in cycle 2, `a_valid`/`b_valid` high from cycle 3.
- Throughput: with both readies held high, one beat per cycle per channel with no bubbles after the first valid.
- Padded beats follow the same latency and ordering as real reads.
- done: one cycle, exactly one cycle after the last of the two final transfers. `running` falls in the same cycle `done` rises.

## Test plan
- Reset check: assert `rst_in` for 2 cycles → all outputs 0, `running`=0. Then `start` with readies low → valids rise at cycle 3 and hold, read_en stops after 2 issues.
- Small layer, readies always 1: W=H=4, IC=OC=2, K=3, act[i]=i+1, wgt[i]=i+1000. Beats 0..5 → a = 0,0,0,0,1,3 and b = 1000..1005. Exactly 576 transfers per channel, `done` pulses once.
- Backpressure on `b` only: b_ready 0 for 10 cycles mid-stream → a stalls within 2 beats, `b_data` stable while stalled, no beat lost or duplicated versus the golden sequence.
- Random ready toggling on both channels (50%) → a/b sequences match the loop-order golden model.
- `start` pulsed during RUN and DRAIN → ignored, beat count still 576, single `done`.
- `rst_in` at beat 100 then new `start` → stream restarts from beat 0 values, no stale FIFO data appears.

Source files
------------

// File: rtl/conv_input_streamer.sv
// Streams activations (a) and weights (b) to the convolution accelerator in
// y, x, oc, ic, ky, kx loop order. Border padding is inserted as zero beats
// without a memory read. Each channel has a two-entry output FIFO.
module conv_input_streamer #(
  parameter int unsigned IO_DATA_WIDTH      = 16,
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned INPUT_NB_CHANNELS  = 64,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  parameter int unsigned KERNEL_SIZE        = 3,
  parameter int unsigned SRC_MEM_HEIGHT     = 1 << 20,
  localparam int unsigned AW                = $clog2(SRC_MEM_HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     start,
  output logic                     running,
  output logic                     done,
  output logic [AW-1:0]            act_mem_read_addr,
  output logic                     act_mem_read_en,
  input  logic [IO_DATA_WIDTH-1:0] act_mem_qout,
  output logic [AW-1:0]            wgt_mem_read_addr,
  output logic                     wgt_mem_read_en,
  input  logic [IO_DATA_WIDTH-1:0] wgt_mem_qout,
  output logic [IO_DATA_WIDTH-1:0] a_data,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [IO_DATA_WIDTH-1:0] b_data,
  output logic                     b_valid,
  input  logic                     b_ready
);

  localparam int unsigned XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
  localparam int unsigned YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int unsigned ICW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1;
  localparam int unsigned OCW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
  localparam int unsigned KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1;
  localparam int unsigned XSW = $clog2(FEATURE_MAP_WIDTH) + 2;
  localparam int unsigned YSW = $clog2(FEATURE_MAP_HEIGHT) + 2;
  localparam int unsigned PAD = (KERNEL_SIZE - 1) / 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [YW-1:0]  y_q, y_d;
  logic [XW-1:0]  x_q, x_d;
  logic [OCW-1:0] oc_q, oc_d;
  logic [ICW-1:0] ic_q, ic_d;
  logic [KW-1:0]  ky_q, ky_d;
  logic [KW-1:0]  kx_q, kx_d;
  logic           rd_q, pad_q, running_q, done_q;

  // Per-channel FIFO: index 0 = a (activation), 1 = b (weight).
  logic [1:0]               hv_q, hv_d, tv_q, tv_d;
  logic [IO_DATA_WIDTH-1:0] hd_q [2];
  logic [IO_DATA_WIDTH-1:0] hd_d [2];
  logic [IO_DATA_WIDTH-1:0] td_q [2];
  logic [IO_DATA_WIDTH-1:0] td_d [2];
  logic [IO_DATA_WIDTH-1:0] push_c [2];
  logic [1:0]               rdy_c, pop_c, room_c;

  logic signed [YSW-1:0] yi_c;
  logic signed [XSW-1:0] xi_c;
  logic                  pad_c, issue_c, last_c;
  logic [AW-1:0]         act_addr_c, wgt_addr_c;

  // Input coordinates of the current tuple and border detection.
  assign yi_c  = $signed(YSW'(y_q)) + $signed(YSW'(ky_q)) - $signed(YSW'(PAD));
  assign xi_c  = $signed(XSW'(x_q)) + $signed(XSW'(kx_q)) - $signed(XSW'(PAD));
  assign pad_c = yi_c[YSW-1] || (yi_c >= $signed(YSW'(FEATURE_MAP_HEIGHT))) ||
                 xi_c[XSW-1] || (xi_c >= $signed(XSW'(FEATURE_MAP_WIDTH)));

  assign act_addr_c = (AW'(yi_c) * AW'(FEATURE_MAP_WIDTH) + AW'(xi_c)) *
                      AW'(INPUT_NB_CHANNELS) + AW'(ic_q);
  assign wgt_addr_c = ((AW'(oc_q) * AW'(INPUT_NB_CHANNELS) + AW'(ic_q)) *
                       AW'(KERNEL_SIZE) + AW'(ky_q)) * AW'(KERNEL_SIZE) + AW'(kx_q);

  assign last_c = (kx_q == KW'(KERNEL_SIZE - 1)) && (ky_q == KW'(KERNEL_SIZE - 1)) &&
                  (ic_q == ICW'(INPUT_NB_CHANNELS - 1)) && (oc_q == OCW'(OUTPUT_NB_CHANNELS - 1)) &&
                  (x_q == XW'(FEATURE_MAP_WIDTH - 1)) && (y_q == YW'(FEATURE_MAP_HEIGHT - 1));

  // Issue only when both FIFOs can absorb the read without overflowing.
  assign rdy_c   = {b_ready, a_ready};
  assign pop_c   = hv_q & rdy_c;
  assign room_c[0] = (3'(hv_q[0]) + 3'(tv_q[0]) + 3'(rd_q)) < (3'd2 + 3'(pop_c[0]));
  assign room_c[1] = (3'(hv_q[1]) + 3'(tv_q[1]) + 3'(rd_q)) < (3'd2 + 3'(pop_c[1]));
  assign issue_c = (state_q == S_RUN) && (&room_c);

  assign act_mem_read_en   = issue_c && !pad_c;
  assign act_mem_read_addr = act_mem_read_en ? act_addr_c : '0;
  assign wgt_mem_read_en   = issue_c;
  assign wgt_mem_read_addr = issue_c ? wgt_addr_c : '0;

  assign push_c[0] = pad_q ? '0 : act_mem_qout;
  assign push_c[1] = wgt_mem_qout;

  // Two-entry FIFO update: head is the output register, tail is the skid slot.
  always_comb begin
    hv_d = hv_q;
    tv_d = tv_q;
    for (int c = 0; c < 2; c++) begin
      hd_d[c] = hd_q[c];
      td_d[c] = td_q[c];
      if (rd_q && !pop_c[c]) begin
        if (!hv_q[c]) begin
          hv_d[c] = 1'b1;
          hd_d[c] = push_c[c];
        end else begin
          tv_d[c] = 1'b1;
          td_d[c] = push_c[c];
        end
      end else if (!rd_q && pop_c[c]) begin
        hv_d[c] = tv_q[c];
        tv_d[c] = 1'b0;
        if (tv_q[c]) hd_d[c] = td_q[c];
      end else if (rd_q && pop_c[c]) begin
        if (tv_q[c]) begin
          hd_d[c] = td_q[c];
          td_d[c] = push_c[c];
        end else begin
          hd_d[c] = push_c[c];
        end
      end
    end
  end

  // Next-state and loop-counter advance.
  always_comb begin
    state_d = state_q;
    y_d = y_q;   x_d = x_q;   oc_d = oc_q;
    ic_d = ic_q; ky_d = ky_q; kx_d = kx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          y_d = '0;  x_d = '0;  oc_d = '0;
          ic_d = '0; ky_d = '0; kx_d = '0;
        end
      end
      S_RUN: begin
        if (issue_c) begin
          if (last_c) state_d = S_DRAIN;
          if (kx_q != KW'(KERNEL_SIZE - 1)) kx_d = kx_q + KW'(1);
          else begin
            kx_d = '0;
            if (ky_q != KW'(KERNEL_SIZE - 1)) ky_d = ky_q + KW'(1);
            else begin
              ky_d = '0;
              if (ic_q != ICW'(INPUT_NB_CHANNELS - 1)) ic_d = ic_q + ICW'(1);
              else begin
                ic_d = '0;
                if (oc_q != OCW'(OUTPUT_NB_CHANNELS - 1)) oc_d = oc_q + OCW'(1);
                else begin
                  oc_d = '0;
                  if (x_q != XW'(FEATURE_MAP_WIDTH - 1)) x_d = x_q + XW'(1);
                  else begin
                    x_d = '0;
                    if (y_q != YW'(FEATURE_MAP_HEIGHT - 1)) y_d = y_q + YW'(1);
                    else y_d = '0;
                  end
                end
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if ((hv_d == 2'b00) && (tv_d == 2'b00)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, in-flight tracking, FIFOs and status registers.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      y_q <= '0;  x_q <= '0;  oc_q <= '0;
      ic_q <= '0; ky_q <= '0; kx_q <= '0;
      rd_q <= 1'b0;
      pad_q <= 1'b0;
      running_q <= 1'b0;
      done_q <= 1'b0;
      hv_q <= '0;
      tv_q <= '0;
      for (int c = 0; c < 2; c++) begin
        hd_q[c] <= '0;
        td_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      y_q <= y_d;   x_q <= x_d;   oc_q <= oc_d;
      ic_q <= ic_d; ky_q <= ky_d; kx_q <= kx_d;
      rd_q <= issue_c;
      pad_q <= pad_c;
      running_q <= (state_d != S_IDLE);
      done_q <= (state_q == S_DRAIN) && (state_d == S_IDLE);
      hv_q <= hv_d;
      tv_q <= tv_d;
      for (int c = 0; c < 2; c++) begin
        hd_q[c] <= hd_d[c];
        td_q[c] <= td_d[c];
      end
    end
  end

  assign running = running_q;
  assign done    = done_q;
  assign a_data  = hd_q[0];
  assign a_valid = hv_q[0];
  assign b_data  = hd_q[1];
  assign b_valid = hv_q[1];

endmodule

// File: tb/tb_conv_input_streamer.sv
// Scoreboard bench for conv_input_streamer on a 4x4x2x2 layer with 3x3 kernel.
module tb_conv_input_streamer;

  localparam int W = 4, H = 4, IC = 2, OC = 2, K = 3, MEMH = 1024;
  localparam int AW = 10;
  localparam int NB = H * W * OC * IC * K * K;

  logic clk = 1'b0;
  logic rst_in = 1'b1, start = 1'b0;
  logic running, done;
  logic [AW-1:0] act_mem_read_addr, wgt_mem_read_addr;
  logic act_mem_read_en, wgt_mem_read_en;
  logic [15:0] act_mem_qout = '0, wgt_mem_qout = '0;
  logic [15:0] a_data, b_data;
  logic a_valid, b_valid;
  logic a_ready = 1'b0, b_ready = 1'b0;

  logic [15:0] act_mem [MEMH];
  logic [15:0] wgt_mem [MEMH];

  logic [15:0] exp_a [$];
  logic [15:0] exp_b [$];
  int checks = 0, passes = 0;
  int a_xfer = 0, b_xfer = 0, done_cnt = 0;
  logic a_stall_p = 1'b0, b_stall_p = 1'b0;
  logic [15:0] a_data_p = '0, b_data_p = '0;

  conv_input_streamer #(
    .IO_DATA_WIDTH(16), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
    .INPUT_NB_CHANNELS(IC), .OUTPUT_NB_CHANNELS(OC), .KERNEL_SIZE(K),
    .SRC_MEM_HEIGHT(MEMH)
  ) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .running(running), .done(done),
    .act_mem_read_addr(act_mem_read_addr), .act_mem_read_en(act_mem_read_en),
    .act_mem_qout(act_mem_qout),
    .wgt_mem_read_addr(wgt_mem_read_addr), .wgt_mem_read_en(wgt_mem_read_en),
    .wgt_mem_qout(wgt_mem_qout),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < MEMH; i++) begin
      act_mem[i] = 16'(i + 1);
      wgt_mem[i] = 16'(i + 1000);
    end
  end

  // Source memories with one-cycle read latency.
  always @(posedge clk) begin
    if (act_mem_read_en) act_mem_qout <= act_mem[act_mem_read_addr];
    if (wgt_mem_read_en) wgt_mem_qout <= wgt_mem[wgt_mem_read_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Golden beat sequence for one full layer, in loop order.
  task automatic push_expected();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int oc = 0; oc < OC; oc++)
          for (int ic = 0; ic < IC; ic++)
            for (int ky = 0; ky < K; ky++)
              for (int kx = 0; kx < K; kx++) begin
                int yi, xi;
                yi = y + ky - (K - 1) / 2;
                xi = x + kx - (K - 1) / 2;
                if (yi < 0 || yi >= H || xi < 0 || xi >= W) exp_a.push_back(16'd0);
                else exp_a.push_back(16'(((yi * W + xi) * IC + ic) + 1));
                exp_b.push_back(16'((((oc * IC + ic) * K + ky) * K + kx) + 1000));
              end
  endtask

  task automatic do_start();
    push_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input bit hold_start);
    int base, n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (rnd) begin
        a_ready = 1'($urandom_range(0, 1));
        b_ready = 1'($urandom_range(0, 1));
      end
      if (hold_start) start = running;
    end
    start = 1'b0;
    chk("done_seen", int'(done_cnt != base), 1);
  endtask

  task automatic end_checks(input int a0, input int b0, input int d0);
    repeat (4) @(posedge clk);
    #1;
    chk("a_transfers", a_xfer - a0, NB);
    chk("b_transfers", b_xfer - b0, NB);
    chk("done_pulses", done_cnt - d0, 1);
    chk("exp_a_left", exp_a.size(), 0);
    chk("exp_b_left", exp_b.size(), 0);
    chk("running_idle", int'(running), 0);
  endtask

  // Monitor: pops the scoreboard on every transfer, checks stall stability.
  always @(negedge clk) begin
    if (rst_in) begin
      exp_a.delete();
      exp_b.delete();
      a_stall_p <= 1'b0;
      b_stall_p <= 1'b0;
    end else begin
      if (a_stall_p) begin
        chk("a_hold_valid", int'(a_valid), 1);
        chk("a_hold_data", int'(a_data), int'(a_data_p));
      end
      if (b_stall_p) begin
        chk("b_hold_valid", int'(b_valid), 1);
        chk("b_hold_data", int'(b_data), int'(b_data_p));
      end
      if (a_valid && a_ready) begin
        if (exp_a.size() == 0) chk("a_extra_beat", int'(a_data), -1);
        else chk("a_beat", int'(a_data), int'(exp_a.pop_front()));
        a_xfer++;
      end
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) chk("b_extra_beat", int'(b_data), -1);
        else chk("b_beat", int'(b_data), int'(exp_b.pop_front()));
        b_xfer++;
      end
      if (done) begin
        done_cnt++;
        chk("running_low_at_done", int'(running), 0);
      end
      a_stall_p <= a_valid && !a_ready;
      b_stall_p <= b_valid && !b_ready;
      a_data_p <= a_data;
      b_data_p <= b_data;
    end
  end

  initial begin
    int a0, b0, d0, n;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_a_valid", int'(a_valid), 0);
    chk("rst_b_valid", int'(b_valid), 0);
    chk("rst_a_data", int'(a_data), 0);
    chk("rst_b_data", int'(b_data), 0);
    chk("rst_act_en", int'(act_mem_read_en), 0);
    chk("rst_wgt_en", int'(wgt_mem_read_en), 0);
    chk("rst_act_addr", int'(act_mem_read_addr), 0);
    chk("rst_wgt_addr", int'(wgt_mem_read_addr), 0);
    rst_in = 1'b0;
    @(posedge clk); #1;

    // Start latency with readies low, then full layer with readies high.
    a0 = a_xfer; b0 = b_xfer; d0 = done_cnt;
    do_start();
    chk("c1_running", int'(running), 1);
    chk("c1_wgt_en", int'(wgt_mem_read_en), 1);
    chk("c1_wgt_addr", int'(wgt_mem_read_addr), 0);
    chk("c1_act_en_pad", int'(act_mem_read_en), 0);
    @(posedge clk); #1;
    chk("c2_a_valid", int'(a_valid), 0);
    chk("c2_b_valid", int'(b_valid), 0);
    chk("c2_wgt_en", int'(wgt_mem_read_en), 1);
    chk("c2_wgt_addr", int'(wgt_mem_read_addr), 1);
    @(posedge clk); #1;
    chk("c3_a_valid", int'(a_valid), 1);
    chk("c3_b_valid", int'(b_valid), 1);
    chk("c3_wgt_en", int'(wgt_mem_read_en), 0);
    @(posedge clk); #1;
    chk("c4_wgt_en", int'(wgt_mem_read_en), 0);
    chk("c4_b_data", int'(b_data), 1000);
    chk("c4_a_data", int'(a_data), 0);
    a_ready = 1'b1;
    b_ready = 1'b1;
    wait_done(3000, 1'b0, 1'b0);
    end_checks(a0, b0, d0);

    // Backpressure on b only.
    a0 = a_xfer; b0 = b_xfer; d0 = done_cnt;
    do_start();
    n = 0;
    while (b_xfer - b0 < 50 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_beat_50", int'(b_xfer - b0 >= 50), 1);
    b_ready = 1'b0;
    n = a_xfer;
    repeat (10) @(posedge clk);
    #1;
    chk("a_stalls_within_2", int'(a_xfer - n <= 2), 1);
    chk("a_valid_stalled", int'(a_valid), 0);
    chk("b_valid_stalled", int'(b_valid), 1);
    b_ready = 1'b1;
    wait_done(3000, 1'b0, 1'b0);
    end_checks(a0, b0, d0);

    // Random readies, start held high throughout RUN and DRAIN.
    a0 = a_xfer; b0 = b_xfer; d0 = done_cnt;
    do_start();
    wait_done(8000, 1'b1, 1'b1);
    a_ready = 1'b1;
    b_ready = 1'b1;
    end_checks(a0, b0, d0);

    // Reset at beat 100, then restart from scratch.
    do_start();
    n = 0;
    while (a_xfer - a0 < NB + 100 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    rst_in = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_running", int'(running), 0);
    chk("mid_rst_a_valid", int'(a_valid), 0);
    chk("mid_rst_b_valid", int'(b_valid), 0);
    chk("mid_rst_a_data", int'(a_data), 0);
    chk("mid_rst_wgt_en", int'(wgt_mem_read_en), 0);
    chk("mid_rst_flushed", exp_a.size() + exp_b.size(), 0);
    rst_in = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", int'(wgt_mem_read_en), 0);
    a0 = a_xfer; b0 = b_xfer; d0 = done_cnt;
    do_start();
    wait_done(3000, 1'b0, 1'b0);
    end_checks(a0, b0, d0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
